// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one external memory port between instruction fetch and the
// data path. One transaction is outstanding at a time. Data has fixed priority, and a
// saturating starvation counter forces a fetch grant after STARVE_LIMIT data grants.
//
// Ports:
//   clk, reset                 clock; synchronous active-high reset
//   i_req/i_addr               fetch request and byte address
//   i_data/i_ack/i_stall       fetched word, one-cycle completion pulse, pipeline stall term
//   d_req/d_we/d_addr/d_wdata  data request, store flag, byte address, store data
//   d_rdata/d_ack/d_stall      load data, one-cycle completion pulse, pipeline stall term
//   mem_req/mem_we/mem_addr/mem_wdata  external port request, held until mem_ready
//   mem_rdata/mem_ready        external read data and completion
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_BITS     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [63:0] i_addr,
  output logic [31:0] i_data,
  output logic        i_ack,
  output logic        i_stall,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [63:0] d_addr,
  input  logic [63:0] d_wdata,
  output logic [63:0] d_rdata,
  output logic        d_ack,
  output logic        d_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  input  logic        mem_ready
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBusyI = 2'd1,
    StBusyD = 2'd2
  } state_e;

  localparam logic [CNT_BITS-1:0] LimitC = CNT_BITS'(STARVE_LIMIT);

  state_e              r_state;
  state_e              w_state_next;
  logic [CNT_BITS-1:0] r_cnt;
  logic [CNT_BITS-1:0] w_cnt_next;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [63:0]         r_mem_addr;
  logic [63:0]         r_mem_wdata;
  logic                r_i_sel;
  logic [31:0]         r_i_data;
  logic [63:0]         r_d_rdata;
  logic                r_i_ack;
  logic                r_d_ack;

  logic w_ir;
  logic w_dr;
  logic w_grant_i;
  logic w_grant_d;
  logic w_done;
  logic w_unused;

  // A port is masked in its ack cycle so the just-completed request is not re-granted.
  assign w_ir = i_req & ~r_i_ack;
  assign w_dr = d_req & ~r_d_ack;

  // Byte-offset bits below the port granularity are intentionally dropped.
  assign w_unused = ^{i_addr[1:0], d_addr[2:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_grant_i    = 1'b0;
    w_grant_d    = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_ir && (!w_dr || r_cnt == LimitC)) begin
          w_grant_i    = 1'b1;
          w_state_next = StBusyI;
        end else if (w_dr) begin
          w_grant_d    = 1'b1;
          w_state_next = StBusyD;
        end
      end
      // mem_req is always high in a busy state, so mem_ready is only honoured here.
      StBusyI, StBusyD: begin
        if (mem_ready) begin
          w_done       = 1'b1;
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    w_cnt_next = r_cnt;
    if (r_state == StIdle) begin
      if (w_grant_i || !w_ir) begin
        w_cnt_next = '0;
      end else if (w_grant_d && r_cnt != LimitC) begin
        w_cnt_next = r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_i_sel     <= 1'b0;
      r_i_data    <= '0;
      r_d_rdata   <= '0;
      r_i_ack     <= 1'b0;
      r_d_ack     <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_next;
      r_i_ack <= w_done && (r_state == StBusyI);
      r_d_ack <= w_done && (r_state == StBusyD);
      if (w_grant_i) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= 1'b0;
        r_mem_addr  <= {i_addr[63:3], 3'b000};
        r_mem_wdata <= '0;
        r_i_sel     <= i_addr[2];
      end else if (w_grant_d) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= d_we;
        r_mem_addr  <= {d_addr[63:3], 3'b000};
        r_mem_wdata <= d_wdata;
      end else if (w_done) begin
        r_mem_req <= 1'b0;
      end
      // Little-endian word select within the returned quadword.
      if (w_done && r_state == StBusyI) begin
        r_i_data <= r_i_sel ? mem_rdata[63:32] : mem_rdata[31:0];
      end
      if (w_done && r_state == StBusyD && !r_mem_we) begin
        r_d_rdata <= mem_rdata;
      end
    end
  end

  assign i_data    = r_i_data;
  assign i_ack     = r_i_ack;
  assign i_stall   = i_req & ~r_i_ack;
  assign d_rdata   = r_d_rdata;
  assign d_ack     = r_d_ack;
  assign d_stall   = d_req & ~r_d_ack;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule
